// File: rtl/sparc_ifu_wselpipe.sv
// Icache way-select pipe: AND-OR way mux for each fetch lane plus an ASI/BIST way read port.
// Latency: fetch s1->s2 1 cycle; ASI request -> wsel_mbist_vld 2 cycles, re-request after 3.
// Backpressure: fetch path has none; ASI accepts only while wsel_ifq_asirdy, holds data until ack.
//
// Ports:
//   rclk, arst_l            clock; async-assert / sync-deassert active-low reset
//   icd_wsel_data_s1        raw way data, lane L way W at [(L*NWAYS+W)*DW +: DW]
//   itlb_wsel_waysel_s1     way select (one-hot or zero), ifq_wsel_fvld_s1 fetch valid
//   wsel_fdp_data_s2/vld_s2 registered selected fetch data (same lane packing), valid
//   wsel_err_s2, wsel_errcnt mutex-error pulse and its saturating 8-bit count
//   ifq_wsel_asireq_f/asiway_f, wsel_ifq_asirdy   ASI read request, way index, ready
//   wsel_mbist_data/vld, mbist_wsel_ack           held ASI read data, valid, consumer ack

module sparc_ifu_wselpipe #(
  parameter  int NWAYS  = 4,
  parameter  int DW     = 34,
  parameter  int NLANES = 2,
  localparam int WW     = (NWAYS > 1) ? $clog2(NWAYS) : 1
) (
  input  logic                     rclk,
  input  logic                     arst_l,

  input  logic [NLANES*NWAYS*DW-1:0] icd_wsel_data_s1,
  input  logic [NWAYS-1:0]         itlb_wsel_waysel_s1,
  input  logic                     ifq_wsel_fvld_s1,

  output logic [NLANES*DW-1:0]     wsel_fdp_data_s2,
  output logic                     wsel_fdp_vld_s2,
  output logic                     wsel_err_s2,
  output logic [7:0]               wsel_errcnt,

  input  logic                     ifq_wsel_asireq_f,
  input  logic [WW-1:0]            ifq_wsel_asiway_f,
  output logic                     wsel_ifq_asirdy,
  output logic [NLANES*DW-1:0]     wsel_mbist_data,
  output logic                     wsel_mbist_vld,
  input  logic                     mbist_wsel_ack
);

  // ---------------------------------------------------------------------------
  // Fetch path
  // ---------------------------------------------------------------------------

  // Flat AND-OR mux: every way is gated by its own select bit and the results
  // are ORed, so a one-hot select passes exactly one way and zero selects none.
  logic [NLANES*DW-1:0] fetch_mux;

  always_comb begin
    fetch_mux = '0;
    for (int l = 0; l < NLANES; l++) begin
      for (int w = 0; w < NWAYS; w++) begin
        fetch_mux[l*DW +: DW] = fetch_mux[l*DW +: DW] |
          (icd_wsel_data_s1[(l*NWAYS + w)*DW +: DW] & {DW{itlb_wsel_waysel_s1[w]}});
      end
    end
  end

  // More than one bit set: clearing the lowest set bit leaves something behind.
  logic multi_hot;
  logic mutex_err;

  assign multi_hot = |(itlb_wsel_waysel_s1 & (itlb_wsel_waysel_s1 - NWAYS'(1)));
  assign mutex_err = ifq_wsel_fvld_s1 & multi_hot;

  // A multi-hot select would OR several ways together; the output is forced to
  // zero instead so downstream never sees a blended instruction word.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      wsel_fdp_data_s2 <= '0;
      wsel_fdp_vld_s2  <= 1'b0;
      wsel_err_s2      <= 1'b0;
      wsel_errcnt      <= 8'd0;
    end else begin
      if (ifq_wsel_fvld_s1) begin
        wsel_fdp_data_s2 <= mutex_err ? '0 : fetch_mux;
      end
      wsel_fdp_vld_s2 <= ifq_wsel_fvld_s1;
      wsel_err_s2     <= mutex_err;
      // Counter moves in the same cycle the error pulse appears.
      if (mutex_err && (wsel_errcnt != 8'hff)) begin
        wsel_errcnt <= wsel_errcnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ASI / BIST way read
  // ---------------------------------------------------------------------------

  typedef enum logic [1:0] {
    ASI_IDLE = 2'd0,
    ASI_CAPT = 2'd1,
    ASI_HOLD = 2'd2
  } asi_state_t;

  asi_state_t      asi_state;
  logic [WW-1:0]   asi_way_q;
  logic [NLANES*DW-1:0] asi_sel;

  // Way chosen by the registered index, all lanes; independent of waysel/fvld.
  always_comb begin
    asi_sel = '0;
    for (int l = 0; l < NLANES; l++) begin
      asi_sel[l*DW +: DW] = icd_wsel_data_s1[(l*NWAYS + int'(asi_way_q))*DW +: DW];
    end
  end

  // Ready and valid are registered alongside the state so both are clean flop
  // outputs; ready is 1 out of reset so the first post-reset cycle accepts.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      asi_state       <= ASI_IDLE;
      asi_way_q       <= '0;
      wsel_mbist_data <= '0;
      wsel_mbist_vld  <= 1'b0;
      wsel_ifq_asirdy <= 1'b1;
    end else begin
      case (asi_state)
        ASI_IDLE: begin
          if (ifq_wsel_asireq_f) begin
            asi_way_q       <= ifq_wsel_asiway_f;
            asi_state       <= ASI_CAPT;
            wsel_ifq_asirdy <= 1'b0;
          end
        end
        ASI_CAPT: begin
          wsel_mbist_data <= asi_sel;
          wsel_mbist_vld  <= 1'b1;
          asi_state       <= ASI_HOLD;
        end
        ASI_HOLD: begin
          // Data stays frozen until the consumer acks; requests are dropped.
          if (mbist_wsel_ack) begin
            wsel_mbist_vld  <= 1'b0;
            wsel_ifq_asirdy <= 1'b1;
            asi_state       <= ASI_IDLE;
          end
        end
        default: begin
          wsel_mbist_vld  <= 1'b0;
          wsel_ifq_asirdy <= 1'b1;
          asi_state       <= ASI_IDLE;
        end
      endcase
    end
  end

endmodule
